ccsds_psk_modulator: RTL and testbench

- Parametrised successor to the fixed 13-bit QPSK symbol mapper in the CCSDS TX chain (CCSDS 131.0-B).
- Accepts 2-bit symbols over a valid/ready handshake and maps them to BPSK, QPSK or OQPSK.
- Holds each symbol for a runtime-programmable number of samples and emits signed I/Q samples with output backpressure.
- Sits between the convolutional encoder/randomiser stage and the pulse-shaping filter/DAC interface.

---
 rtl/ccsds_psk_modulator.sv | 125 ++++++++++++
 tb/tb_ccsds_psk_modulator.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/ccsds_psk_modulator.sv
// CCSDS BPSK/QPSK/OQPSK symbol mapper with programmable samples-per-symbol
// and valid/ready handshakes on both the symbol input and the I/Q output.
module ccsds_psk_modulator #(
    parameter int DATA_W = 13,
    parameter int SPS_W  = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [1:0]               mode_i,
    input  logic [SPS_W-1:0]         samples_per_symbol_i,
    input  logic [1:0]               bits_i,
    input  logic                     bits_valid_i,
    output logic                     bits_ready_o,
    output logic signed [DATA_W-1:0] i_data_o,
    output logic signed [DATA_W-1:0] q_data_o,
    output logic                     iq_valid_o,
    input  logic                     iq_ready_i,
    output logic                     underrun_o
);

    typedef enum logic {S_IDLE, S_RUN} state_e;
    typedef enum logic [1:0] {
        M_BPSK  = 2'd0,
        M_QPSK  = 2'd1,
        M_OQPSK = 2'd2,
        M_RSVD  = 2'd3
    } mode_e;

    localparam logic signed [DATA_W-1:0] AMP_P = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] AMP_N = {1'b1, {(DATA_W-2){1'b0}}, 1'b1};
    localparam logic [SPS_W-1:0]         ONE   = SPS_W'(1);

    state_e                   r_state;
    mode_e                    r_mode;
    logic [SPS_W-1:0]         r_sps;
    logic [SPS_W-1:0]         r_cnt;
    logic                     r_qbit;
    logic signed [DATA_W-1:0] r_i;
    logic signed [DATA_W-1:0] r_q;
    logic                     r_valid;
    logic                     r_underrun;

    logic [SPS_W-1:0]         w_sps_in;
    logic [SPS_W-1:0]         w_half;
    logic [SPS_W-1:0]         w_cnt_nx;
    logic                     w_last;
    mode_e                    w_ld_mode;
    logic [SPS_W-1:0]         w_ld_half;
    logic signed [DATA_W-1:0] w_ld_i;
    logic signed [DATA_W-1:0] w_ld_q;
    logic                     w_ld_q_now;

    function automatic logic signed [DATA_W-1:0] amp(input logic b);
        return b ? AMP_N : AMP_P;
    endfunction

    // Load decode uses live mode/SPS in IDLE (they are being latched) and the
    // latched copies while running, so mid-run input changes are ignored.
    always_comb begin
        w_sps_in   = (samples_per_symbol_i == '0) ? ONE : samples_per_symbol_i;
        w_half     = r_sps >> 1;
        w_cnt_nx   = r_cnt + ONE;
        w_last     = (r_cnt == r_sps - ONE);
        w_ld_mode  = (r_state == S_IDLE) ? mode_e'(mode_i) : r_mode;
        w_ld_half  = ((r_state == S_IDLE) ? w_sps_in : r_sps) >> 1;
        w_ld_i     = (w_ld_mode == M_BPSK) ? amp(bits_i[0]) : amp(bits_i[1]);
        w_ld_q     = (w_ld_mode == M_BPSK) ? '0 : amp(bits_i[0]);
        w_ld_q_now = !((w_ld_mode == M_OQPSK) && (w_ld_half != '0));
    end

    assign bits_ready_o = (r_state == S_IDLE) || (iq_ready_i && w_last);
    assign i_data_o     = r_i;
    assign q_data_o     = r_q;
    assign iq_valid_o   = r_valid;
    assign underrun_o   = r_underrun;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_mode     <= M_QPSK;
            r_sps      <= ONE;
            r_cnt      <= '0;
            r_qbit     <= 1'b0;
            r_i        <= '0;
            r_q        <= '0;
            r_valid    <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= 1'b0;
            if (r_state == S_IDLE) begin
                if (bits_valid_i) begin
                    r_state <= S_RUN;
                    r_mode  <= mode_e'(mode_i);
                    r_sps   <= w_sps_in;
                    r_cnt   <= '0;
                    r_i     <= w_ld_i;
                    r_q     <= w_ld_q_now ? w_ld_q : '0;
                    r_qbit  <= bits_i[0];
                    r_valid <= 1'b1;
                end
            end else if (iq_ready_i) begin
                if (!w_last) begin
                    r_cnt <= w_cnt_nx;
                    // OQPSK: Q of the current symbol lands half a symbol late
                    if (r_mode == M_OQPSK && w_cnt_nx == w_half)
                        r_q <= amp(r_qbit);
                end else if (bits_valid_i) begin
                    r_cnt  <= '0;
                    r_i    <= w_ld_i;
                    r_qbit <= bits_i[0];
                    if (w_ld_q_now)
                        r_q <= w_ld_q;
                end else begin
                    r_state    <= S_IDLE;
                    r_cnt      <= '0;
                    r_i        <= '0;
                    r_q        <= '0;
                    r_valid    <= 1'b0;
                    r_underrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ccsds_psk_modulator.sv
// Directed table-driven bench for ccsds_psk_modulator (DATA_W = 13).
module tb_ccsds_psk_modulator;

    localparam int DW = 13;
    localparam int SW = 16;
    localparam int P  = 4095;
    localparam int N  = -4095;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [1:0]           mode;
    logic [SW-1:0]        sps;
    logic [1:0]           bits;
    logic                 bits_valid;
    logic                 bits_ready;
    logic signed [DW-1:0] i_data;
    logic signed [DW-1:0] q_data;
    logic                 iq_valid;
    logic                 iq_ready;
    logic                 underrun;

    always #5 clk = ~clk;

    ccsds_psk_modulator #(.DATA_W(DW), .SPS_W(SW)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .mode_i(mode),
        .samples_per_symbol_i(sps),
        .bits_i(bits),
        .bits_valid_i(bits_valid),
        .bits_ready_o(bits_ready),
        .i_data_o(i_data),
        .q_data_o(q_data),
        .iq_valid_o(iq_valid),
        .iq_ready_i(iq_ready),
        .underrun_o(underrun)
    );

    typedef struct {
        logic       rst;
        logic [1:0] mode;
        int         sps;
        logic [1:0] bits;
        logic       bv;
        logic       rdy;
        int         ei;
        int         eq;
        logic       ev;
        logic       ebr;
        logic       eu;
    } vec_t;

    vec_t tbl[$];
    int   errors = 0;
    int   checks = 0;

    task automatic add(input logic [1:0] m, input int s, input logic [1:0] b,
                       input logic bv, input logic rdy, input int ei, input int eq,
                       input logic ev, input logic ebr, input logic eu);
        vec_t v;
        v.rst = 1'b0; v.mode = m; v.sps = s; v.bits = b; v.bv = bv; v.rdy = rdy;
        v.ei = ei; v.eq = eq; v.ev = ev; v.ebr = ebr; v.eu = eu;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s step%0d got=%0d exp=%0d", name, idx, got, exp);
        end
    endtask

    // Drive just after the rising edge, compare on the falling edge.
    task automatic step(input vec_t v, input int idx);
        @(posedge clk);
        #1;
        rst        = v.rst;
        mode       = v.mode;
        sps        = SW'(v.sps);
        bits       = v.bits;
        bits_valid = v.bv;
        iq_ready   = v.rdy;
        @(negedge clk);
        chk("i_data",     idx, int'(i_data),     v.ei);
        chk("q_data",     idx, int'(q_data),     v.eq);
        chk("iq_valid",   idx, int'(iq_valid),   int'(v.ev));
        chk("bits_ready", idx, int'(bits_ready), int'(v.ebr));
        chk("underrun",   idx, int'(underrun),   int'(v.eu));
    endtask

    initial begin
        vec_t v;

        // QPSK, SPS=1, back-to-back then starvation
        add(1,1,0,1,1, 0,0,0,1,0);
        add(1,1,2,1,1, P,P,1,1,0);
        add(1,1,3,1,1, N,P,1,1,0);
        add(1,1,1,1,1, N,N,1,1,0);
        add(1,1,0,1,1, P,N,1,1,0);
        add(1,1,0,0,1, P,P,1,1,0);
        add(1,1,0,0,1, 0,0,0,1,1);
        add(1,1,0,0,1, 0,0,0,1,0);
        // QPSK, SPS=2
        add(1,2,0,1,1, 0,0,0,1,0);
        add(1,2,2,1,1, P,P,1,0,0);
        add(1,2,2,1,1, P,P,1,1,0);
        add(1,2,3,1,1, N,P,1,0,0);
        add(1,2,3,1,1, N,P,1,1,0);
        add(1,2,1,1,1, N,N,1,0,0);
        add(1,2,1,1,1, N,N,1,1,0);
        add(1,2,0,1,1, P,N,1,0,0);
        add(1,2,0,1,1, P,N,1,1,0);
        add(1,2,0,0,1, P,P,1,0,0);
        add(1,2,0,0,1, P,P,1,1,0);
        add(1,2,0,0,1, 0,0,0,1,1);
        // OQPSK, SPS=4, symbols 11 then 00
        add(2,4,3,1,1, 0,0,0,1,0);
        add(2,4,0,1,1, N,0,1,0,0);
        add(2,4,0,1,1, N,0,1,0,0);
        add(2,4,0,1,1, N,N,1,0,0);
        add(2,4,0,1,1, N,N,1,1,0);
        add(2,4,0,0,1, P,N,1,0,0);
        add(2,4,0,0,1, P,N,1,0,0);
        add(2,4,0,0,1, P,P,1,0,0);
        add(2,4,0,0,1, P,P,1,1,0);
        add(2,4,0,0,1, 0,0,0,1,1);
        // BPSK, SPS=1, symbols 01, 10
        add(0,1,1,1,1, 0,0,0,1,0);
        add(0,1,2,1,1, N,0,1,1,0);
        add(0,1,0,0,1, P,0,1,1,0);
        add(0,1,0,0,1, 0,0,0,1,1);
        // OQPSK, SPS=1 behaves as QPSK
        add(2,1,3,1,1, 0,0,0,1,0);
        add(2,1,1,1,1, N,N,1,1,0);
        add(2,1,0,0,1, P,N,1,1,0);
        add(2,1,0,0,1, 0,0,0,1,1);
        // reserved mode as QPSK, SPS=0 as 1
        add(3,0,2,1,1, 0,0,0,1,0);
        add(3,0,0,0,1, N,P,1,1,0);
        add(3,0,0,0,1, 0,0,0,1,1);
        // QPSK, SPS=3 with stalls; mode/SPS inputs change during RUN
        add(1,3,1,1,1, 0,0,0,1,0);
        add(0,1,2,1,1, P,N,1,0,0);
        for (int k = 0; k < 5; k++) add(0,1,2,1,0, P,N,1,0,0);
        add(0,1,2,1,1, P,N,1,0,0);
        add(0,1,2,1,1, P,N,1,1,0);
        add(0,1,0,0,1, N,P,1,0,0);
        add(0,1,0,0,1, N,P,1,0,0);
        add(0,1,0,0,0, N,P,1,0,0);
        add(0,1,0,0,1, N,P,1,1,0);
        add(0,1,0,0,1, 0,0,0,1,1);

        rst = 1'b1; mode = 2'd1; sps = SW'(1); bits = 2'b00;
        bits_valid = 1'b0; iq_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_i_data",     0, int'(i_data),     0);
        chk("rst_q_data",     0, int'(q_data),     0);
        chk("rst_iq_valid",   0, int'(iq_valid),   0);
        chk("rst_bits_ready", 0, int'(bits_ready), 1);
        chk("rst_underrun",   0, int'(underrun),   0);

        for (int idx = 0; idx < tbl.size(); idx++)
            step(tbl[idx], idx + 1);

        // Reset asserted during the 2nd sample of an SPS=4 symbol
        v = '{rst:1'b0, mode:2'd1, sps:4, bits:2'b11, bv:1'b1, rdy:1'b1,
              ei:0, eq:0, ev:1'b0, ebr:1'b1, eu:1'b0};
        step(v, 100);
        v.bv = 1'b0; v.ei = N; v.eq = N; v.ev = 1'b1; v.ebr = 1'b0;
        step(v, 101);
        v.rst = 1'b1;
        step(v, 102);
        v.rst = 1'b0; v.ei = 0; v.eq = 0; v.ev = 1'b0; v.ebr = 1'b1;
        for (int k = 0; k < 4; k++)
            step(v, 103 + k);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
